// File: rtl/sigmoid_pkg.sv
// sigmoid_pkg: shared Q4.12 definitions and the segment table for the
// piecewise-constant sigmoid LUT.
//   DATA_W / FRAC_W : operand width and fractional bits (Q4.12)
//   SIG_ONE/SIG_ZERO: saturated outputs
//   seg_lut()       : value for 0.2-wide segment idx (0 = [-3.0,-2.8))
package sigmoid_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 12;

    typedef logic [DATA_W-1:0] q4_12_t;

    localparam q4_12_t SIG_ONE  = 16'h1000;
    localparam q4_12_t SIG_ZERO = 16'h0000;

    // Each entry is sigmoid at the segment midpoint, in Q4.12.
    function automatic q4_12_t seg_lut(input logic [5:0] idx);
        case (idx)
            6'd0:  seg_lut = 16'd213;
            6'd1:  seg_lut = 16'd258;
            6'd2:  seg_lut = 16'd311;
            6'd3:  seg_lut = 16'd373;
            6'd4:  seg_lut = 16'd447;
            6'd5:  seg_lut = 16'd533;
            6'd6:  seg_lut = 16'd633;
            6'd7:  seg_lut = 16'd747;
            6'd8:  seg_lut = 16'd877;
            6'd9:  seg_lut = 16'd1023;
            6'd10: seg_lut = 16'd1184;
            6'd11: seg_lut = 16'd1359;
            6'd12: seg_lut = 16'd1546;
            6'd13: seg_lut = 16'd1743;
            6'd14: seg_lut = 16'd1946;
            6'd15: seg_lut = 16'd2150;
            6'd16: seg_lut = 16'd2353;
            6'd17: seg_lut = 16'd2550;
            6'd18: seg_lut = 16'd2737;
            6'd19: seg_lut = 16'd2912;
            6'd20: seg_lut = 16'd3073;
            6'd21: seg_lut = 16'd3219;
            6'd22: seg_lut = 16'd3349;
            6'd23: seg_lut = 16'd3463;
            6'd24: seg_lut = 16'd3563;
            6'd25: seg_lut = 16'd3649;
            6'd26: seg_lut = 16'd3723;
            6'd27: seg_lut = 16'd3785;
            6'd28: seg_lut = 16'd3838;
            6'd29: seg_lut = 16'd3882;
            6'd30: seg_lut = 16'd3919;
            6'd31: seg_lut = 16'd3950;
            6'd32: seg_lut = 16'd3976;
            6'd33: seg_lut = 16'd3997;
            6'd34: seg_lut = 16'd4014;
            default: seg_lut = SIG_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   en      : grant enable
//   gnt     : one-hot-or-zero grant
//   gnt_idx : index of the granted requester
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    always_comb begin : arb
        logic        found;
        int unsigned k;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = 32'(ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (en && !found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/sigmoid.sv
// sigmoid: combinational piecewise-constant sigmoid.
//   x : Q4.12 signed operand
//   y : Q4.12 unsigned result, 0x0000..0x1000
module sigmoid
    import sigmoid_pkg::*;
(
    input  q4_12_t x,
    output q4_12_t y
);

    logic [14:0] u;
    logic [5:0]  idx;

    always_comb begin
        // Offset by +3.0 so [-3.0, 4.0) maps to 0..0x6FFF; the 0.2-step
        // segment index is then exactly floor(u * 5 / 4096).
        u   = x[14:0] + 15'h3000;
        idx = 6'((32'(u) * 32'd5) >> 12);
        if (!x[15] && x[14]) begin
            y = SIG_ONE;
        end else if (x[15] && (x[14:12] <= 3'b100)) begin
            y = SIG_ZERO;
        end else begin
            y = seg_lut(idx);
        end
    end

endmodule

// File: rtl/sigmoid_share_ctrl.sv
// sigmoid_share_ctrl: shares one sigmoid LUT among NUM_REQ requesters.
// Two-stage pipeline (operand register, result register), whole pipeline
// stalls on output back-pressure.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_data  : per-requester Q4.12 operands (16 bits each)
//   req_ready           : one-hot-or-zero grant
//   out_valid/out_data  : registered sigmoid result
//   out_id              : requester index of the result
//   out_ready           : downstream accept
//   busy                : either stage holds valid data
module sigmoid_share_ctrl
    import sigmoid_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready,
    output logic                      busy
);

    logic                advance;
    logic [ID_W-1:0]     ptr;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                accept;
    logic                s1_valid;
    q4_12_t              s1_x;
    logic [ID_W-1:0]     s1_id;
    q4_12_t              lut_y;

    assign advance = !out_valid || out_ready;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (advance && !reset),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    sigmoid u_lut (
        .x (s1_x),
        .y (lut_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_id     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            out_data  <= lut_y;
            out_id    <= s1_id;
            s1_valid  <= accept;
            if (accept) begin
                s1_x  <= req_data[DATA_W*gnt_idx +: DATA_W];
                s1_id <= gnt_idx;
                ptr   <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
            end
        end
    end

    assign busy = s1_valid || out_valid;

endmodule

// File: tb/tb_sigmoid_share_ctrl.sv
// tb_sigmoid_share_ctrl: directed, table-driven bench for sigmoid_share_ctrl
// with NUM_REQ = 4. Inputs change and outputs are sampled around the
// falling edge; the DUT acts on the rising edge.
module tb_sigmoid_share_ctrl;

    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [16*NR-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            out_valid;
    logic [15:0]     out_data;
    logic [1:0]      out_id;
    logic            out_ready;
    logic            busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [15:0] x;
        logic [15:0] y;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    sigmoid_share_ctrl #(.NUM_REQ(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input int id, input logic [15:0] d);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_id"}, 32'(out_id), 32'(id));
        chk({name, "_data"}, 32'(out_data), 32'(d));
    endtask

    task automatic set_op(input int i, input logic [15:0] x);
        req_valid[i] = 1'b1;
        req_data[16*i +: 16] = x;
    endtask

    // Advance one clock; optionally drop the requests that were accepted.
    task automatic tick(input bit drop);
        logic [NR-1:0] acc;
        acc = req_valid & req_ready;
        @(posedge clk);
        @(negedge clk);
        if (drop) req_valid = req_valid & ~acc;
        #1;
    endtask

    task automatic run_single(input int id, input logic [15:0] x, input logic [15:0] y);
        set_op(id, x);
        out_ready = 1'b1;
        #1;
        chk("single_grant", 32'(req_ready), 32'd1 << id);
        tick(1);
        chk("single_lat_valid", 32'(out_valid), 32'd0);
        chk("single_lat_busy", 32'(busy), 32'd1);
        tick(1);
        chk_out("single_out", id, y);
        tick(1);
        chk("single_done_valid", 32'(out_valid), 32'd0);
        chk("single_done_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 16'h0000, 16'h0866};
        vecs[1] = '{0, 16'hF000, 16'h04A0};
        vecs[2] = '{2, 16'h1000, 16'h0C01};
        vecs[3] = '{3, 16'h4000, 16'h1000};
        vecs[4] = '{1, 16'h8000, 16'h0000};
        vecs[5] = '{2, 16'h3FFF, 16'h0FAE};
        vecs[6] = '{0, 16'hD000, 16'h00D5};
        vecs[7] = '{1, 16'h7FFF, 16'h1000};
        vecs[8] = '{3, 16'hCFFF, 16'h0000};

        // Reset state: no grants while reset is high even with requests.
        reset     = 1'b1;
        req_valid = '1;
        req_data  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_id", 32'(out_id), 32'd0);
        reset     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        #1;

        // LUT vectors, one requester at a time.
        for (int v = 0; v < 9; v++) begin
            run_single(vecs[v].id, vecs[v].x, vecs[v].y);
        end

        // All four requesting from reset: results back-to-back in id order.
        do_reset();
        out_ready = 1'b1;
        set_op(0, 16'hF000);
        set_op(1, 16'h1000);
        set_op(2, 16'h4000);
        set_op(3, 16'h8000);
        #1;
        chk("all4_g0", 32'(req_ready), 32'b0001);
        tick(1);
        chk("all4_g1", 32'(req_ready), 32'b0010);
        chk("all4_nv", 32'(out_valid), 32'd0);
        tick(1);
        chk("all4_g2", 32'(req_ready), 32'b0100);
        chk_out("all4_r0", 0, 16'h04A0);
        tick(1);
        chk("all4_g3", 32'(req_ready), 32'b1000);
        chk_out("all4_r1", 1, 16'h0C01);
        tick(1);
        chk("all4_gnone", 32'(req_ready), 32'b0000);
        chk_out("all4_r2", 2, 16'h1000);
        tick(1);
        chk_out("all4_r3", 3, 16'h0000);
        tick(1);
        chk("all4_end_valid", 32'(out_valid), 32'd0);
        chk("all4_end_busy", 32'(busy), 32'd0);

        // Back-pressure: five stalled cycles, then in-order drain.
        set_op(0, 16'h0000);
        set_op(1, 16'h1000);
        #1;
        chk("bp_g0", 32'(req_ready), 32'b0001);
        tick(1);
        chk("bp_g1", 32'(req_ready), 32'b0010);
        tick(1);
        out_ready = 1'b0;
        set_op(2, 16'hF000);
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_stall_ready", 32'(req_ready), 32'd0);
            chk_out("bp_stall", 0, 16'h0866);
            chk("bp_stall_busy", 32'(busy), 32'd1);
            tick(1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'b0100);
        tick(1);
        chk_out("bp_r1", 1, 16'h0C01);
        tick(1);
        chk_out("bp_r2", 2, 16'h04A0);
        tick(1);
        chk("bp_end_valid", 32'(out_valid), 32'd0);

        // Fairness: 0 and 2 held valid; pointer sits at 3 and wraps to 0.
        set_op(0, 16'h0000);
        set_op(2, 16'h4000);
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("fair_grant", 32'(req_ready), (g % 2 == 0) ? 32'b0001 : 32'b0100);
            if (g == 2) chk_out("fair_r0", 0, 16'h0866);
            if (g == 3) chk_out("fair_r1", 2, 16'h1000);
            tick(0);
        end
        chk_out("fair_r2", 0, 16'h0866);

        // Reset mid-stall with both stages full; last grant was 2.
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        chk("mrst_ready", 32'(req_ready), 32'd0);
        chk("mrst_busy_before", 32'(busy), 32'd1);
        tick(0);
        reset     = 1'b0;
        req_valid = '0;
        set_op(1, 16'hD000);
        set_op(3, 16'hCFFF);
        out_ready = 1'b1;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_grant_low", 32'(req_ready), 32'b0010);
        tick(1);
        chk("mrst_no_stale", 32'(out_valid), 32'd0);
        chk("mrst_g3", 32'(req_ready), 32'b1000);
        tick(1);
        chk_out("mrst_r1", 1, 16'h00D5);
        tick(1);
        chk_out("mrst_r3", 3, 16'h0000);
        tick(1);
        chk("mrst_end_valid", 32'(out_valid), 32'd0);
        chk("mrst_end_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
